// File: rtl/bpred_resolve_queue_if.sv
// Fetch/execute/predictor-update signal bundle for bpred_resolve_queue.
// The slave modport is the queue's view. The master modport is the surrounding pipeline's view.
interface bpred_resolve_queue_if;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_pc4;
   logic        fetch_p_dir;
   logic [31:0] fetch_p_target;
   logic [11:0] fetch_bimodal;
   logic        fetch_is_call;
   logic        fetch_is_ret;
   logic        exec_valid;
   logic        exec_is_branch;
   logic        exec_taken;
   logic [31:0] exec_target;
   logic        stall;
   logic        upd_valid;
   logic [31:0] upd_pc4;
   logic [31:0] upd_target;
   logic        upd_dir;
   logic        upd_miss;
   logic [11:0] upd_bimodal;
   logic        miss_pred;
   logic        c_r_after_r;
   logic        upd_is_call;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        underflow;

   modport master (
      output fetch_valid, fetch_pc4, fetch_p_dir, fetch_p_target, fetch_bimodal,
             fetch_is_call, fetch_is_ret, exec_valid, exec_is_branch, exec_taken,
             exec_target, stall,
      input  fetch_ready, upd_valid, upd_pc4, upd_target, upd_dir, upd_miss,
             upd_bimodal, miss_pred, c_r_after_r, upd_is_call, redirect_valid,
             redirect_pc, underflow
   );

   modport slave (
      input  fetch_valid, fetch_pc4, fetch_p_dir, fetch_p_target, fetch_bimodal,
             fetch_is_call, fetch_is_ret, exec_valid, exec_is_branch, exec_taken,
             exec_target, stall,
      output fetch_ready, upd_valid, upd_pc4, upd_target, upd_dir, upd_miss,
             upd_bimodal, miss_pred, c_r_after_r, upd_is_call, redirect_valid,
             redirect_pc, underflow
   );
endinterface

// File: rtl/bpred_resolve_queue.sv
// Branch-prediction resolve queue: holds fetch-time prediction metadata until execute, then drives predictor update, RAS repair and redirect.
// Optional BPRQ_UPD_SKID_EN: holds a stalled predictor update until stall drops.
module bpred_resolve_queue #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   bpred_resolve_queue_if.slave bus
);

`ifdef BPRQ_UPD_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] pc4;
      logic        p_dir;
      logic [31:0] p_target;
      logic [11:0] bimodal;
      logic        is_call;
      logic        is_ret;
   } entry_t;

   entry_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_head, r_tail;
   logic [PTR_W:0]   r_count;
   logic             r_prev_ret;
   logic             r_upd_valid, r_upd_dir, r_upd_miss, r_upd_is_call;
   logic [31:0]      r_upd_pc4, r_upd_target;
   logic [11:0]      r_upd_bimodal;
   logic             r_miss_pred, r_c_r_after_r, r_redirect_valid, r_underflow;
   logic [31:0]      r_redirect_pc;

   entry_t w_head_e;
   logic   w_full, w_empty, w_hold, w_ready, w_pop, w_br, w_miss, w_push;

   always_comb begin
      w_head_e = r_mem[r_head];
      w_full   = (r_count == (PTR_W+1)'(DEPTH));
      w_empty  = (r_count == '0);
      // A held update stays on the bus while the predictor is stalled; fetch backs off meanwhile
      w_hold   = SKID & r_upd_valid & bus.stall;
      w_ready  = ~w_full & ~w_hold;
      w_pop    = bus.exec_valid & ~w_empty;
      w_br     = w_pop & bus.exec_is_branch;
      w_miss   = w_br & ((bus.exec_taken != w_head_e.p_dir) |
                         (bus.exec_taken & w_head_e.p_dir &
                          (bus.exec_target != w_head_e.p_target)));
      w_push   = bus.fetch_valid & w_ready & ~w_miss;
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_tail].pc4      <= bus.fetch_pc4;
         r_mem[r_tail].p_dir    <= bus.fetch_p_dir;
         r_mem[r_tail].p_target <= bus.fetch_p_target;
         r_mem[r_tail].bimodal  <= bus.fetch_bimodal;
         r_mem[r_tail].is_call  <= bus.fetch_is_call;
         r_mem[r_tail].is_ret   <= bus.fetch_is_ret;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_miss) begin
            // Flush: everything younger than the mispredicted branch is wrong-path
            r_head  <= r_tail;
            r_count <= '0;
         end else begin
            if (w_pop) r_head <= r_head + 1'b1;
            r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev_ret       <= 1'b0;
         r_upd_valid      <= 1'b0;
         r_upd_pc4        <= '0;
         r_upd_target     <= '0;
         r_upd_dir        <= 1'b0;
         r_upd_miss       <= 1'b0;
         r_upd_bimodal    <= '0;
         r_upd_is_call    <= 1'b0;
         r_miss_pred      <= 1'b0;
         r_c_r_after_r    <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_underflow      <= 1'b0;
      end else begin
         r_underflow      <= r_underflow | (bus.exec_valid & w_empty);
         r_miss_pred      <= w_miss;
         r_redirect_valid <= w_miss;
         r_redirect_pc    <= w_miss ? (bus.exec_taken ? bus.exec_target : w_head_e.pc4) : '0;
         r_c_r_after_r    <= w_br & (w_head_e.is_call | w_head_e.is_ret) & r_prev_ret;
         if (w_br) r_prev_ret <= w_head_e.is_ret;
         // A fresh update replaces a held one; otherwise hold or retire the strobe
         if (w_br) begin
            r_upd_valid   <= 1'b1;
            r_upd_pc4     <= w_head_e.pc4;
            r_upd_target  <= bus.exec_target;
            r_upd_dir     <= bus.exec_taken;
            r_upd_miss    <= w_miss;
            r_upd_bimodal <= w_head_e.bimodal;
            r_upd_is_call <= w_head_e.is_call;
         end else if (!w_hold) begin
            r_upd_valid   <= 1'b0;
            r_upd_is_call <= 1'b0;
         end
      end
   end

   assign bus.fetch_ready    = w_ready;
   assign bus.upd_valid      = r_upd_valid;
   assign bus.upd_pc4        = r_upd_pc4;
   assign bus.upd_target     = r_upd_target;
   assign bus.upd_dir        = r_upd_dir;
   assign bus.upd_miss       = r_upd_miss;
   assign bus.upd_bimodal    = r_upd_bimodal;
   assign bus.upd_is_call    = r_upd_is_call;
   assign bus.miss_pred      = r_miss_pred;
   assign bus.c_r_after_r    = r_c_r_after_r;
   assign bus.redirect_valid = r_redirect_valid;
   assign bus.redirect_pc    = r_redirect_pc;
   assign bus.underflow      = r_underflow;

endmodule
